// File: rtl/sipo_ctrl_pkg.sv
// Shared types and constants for the serial-in/parallel-out word controller.
// Optional parity framing is enabled by defining SIPO_PARITY_EN.
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// Left-shifting serial-to-parallel register; new bits enter at the LSB so the
// first bit received ends up in the MSB.
module sipo_shift_reg
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            data_q <= '0;
        end else if (en) begin
            data_q <= {data_q[WIDTH-2:0], d};
        end
    end

    assign q = data_q;

endmodule

// File: rtl/sipo_word_ctrl.sv
// Frames a serial bit stream into WIDTH-bit words and offers them on a
// valid/ready handshake. Define SIPO_PARITY_EN to append an even-parity bit.
module sipo_word_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             x_i,
    input  logic             x_valid_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] bit_cnt_o,
`ifdef SIPO_PARITY_EN
    output logic             parity_err_o,
`endif
    output logic             overrun_o
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             wordValid_q, wordValid_d;
    logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
    logic             parityErr_q, parityErr_d;
`endif

    logic             srClr;
    logic             srEn;
    logic [WIDTH-1:0] srQ;
    logic             lastBit;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (srClr),
        .en    (srEn),
        .d     (x_i),
        .q     (srQ)
    );

    assign lastBit = x_valid_i && (bitCnt_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            word_q      <= '0;
            wordValid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            word_q      <= word_d;
            wordValid_q <= wordValid_d;
            overrun_q   <= overrun_d;
`ifdef SIPO_PARITY_EN
            parityErr_q <= parityErr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        word_d      = word_q;
        wordValid_d = wordValid_q;
        overrun_d   = overrun_q;
`ifdef SIPO_PARITY_EN
        parityErr_d = parityErr_q;
`endif
        srClr       = 1'b0;
        srEn        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = SHIFT;
                    srClr    = 1'b1;
                    bitCnt_d = '0;
                end
            end

            SHIFT: begin
                if (start_i) begin
                    overrun_d = 1'b1;
                end
                if (x_valid_i) begin
                    bitCnt_d = bitCnt_q + CNT_W'(1);
`ifdef SIPO_PARITY_EN
                    // The parity bit closes the frame but never enters the data word.
                    srEn = !lastBit;
`else
                    srEn = 1'b1;
`endif
                end
                if (lastBit) begin
                    state_d     = DONE;
                    wordValid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                    word_d      = srQ;
                    parityErr_d = ^{srQ, x_i};
`else
                    word_d      = (srQ << 1) | WIDTH'(x_i);
`endif
                end
            end

            DONE: begin
                if (x_valid_i) begin
                    overrun_d = 1'b1;
                end
                if (word_ready_i) begin
                    wordValid_d = 1'b0;
                    bitCnt_d    = '0;
                    if (start_i) begin
                        state_d = SHIFT;
                        srClr   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start_i) begin
                    overrun_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign word_o       = word_q;
    assign word_valid_o = wordValid_q;
    assign bit_cnt_o    = bitCnt_q;
    assign overrun_o    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign parity_err_o = parityErr_q;
`endif

endmodule

// File: tb/tb_sipo_word_ctrl.sv
// Self-checking bench for sipo_word_ctrl: table of frames plus hand-written
// corner sequences, with expected words queued as each frame is sent.
module tb_sipo_word_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par;
        bit               gapped;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             startIn = 1'b0;
    logic             xIn = 1'b0;
    logic             xValid = 1'b0;
    logic             readyIn = 1'b0;
    logic [WIDTH-1:0] word;
    logic             wordValid;
    logic             busy;
    logic [CNT_W-1:0] bitCnt;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parityErr;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t expQ[$];
    vec_t vecs[$];

    sipo_word_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (startIn),
        .x_i          (xIn),
        .x_valid_i    (xValid),
        .word_o       (word),
        .word_valid_o (wordValid),
        .word_ready_i (readyIn),
        .busy_o       (busy),
        .bit_cnt_o    (bitCnt),
`ifdef SIPO_PARITY_EN
        .parity_err_o (parityErr),
`endif
        .overrun_o    (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("rst_word", word, 0);
        checkOutput("rst_valid", wordValid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cnt", bitCnt, 0);
        checkOutput("rst_overrun", overrun, 0);
`ifdef SIPO_PARITY_EN
        checkOutput("rst_parity_err", parityErr, 0);
`endif
    endtask

    // Sends one frame MSB first; startAt >= 0 injects a stray start before that bit.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic par, input bit gapped,
                                 input bit doStart, input int startAt);
        exp_t e;
        logic b;
        if (doStart) begin
            startIn = 1'b1;
            step();
            startIn = 1'b0;
            checkOutput("start_busy", busy, 1);
            checkOutput("start_cnt", bitCnt, 0);
        end
        for (int i = 0; i < FRAME; i++) begin
            b = (i < WIDTH) ? data[WIDTH-1-i] : par;
            if (i == startAt) begin
                startIn = 1'b1;
                xValid  = 1'b0;
                step();
                startIn = 1'b0;
                checkOutput("overrun_set", overrun, 1);
                checkOutput("overrun_cnt_hold", bitCnt, i);
            end
            if (gapped && i > 0) begin
                xValid = 1'b0;
                step();
                checkOutput("gap_cnt_hold", bitCnt, i);
            end
            xIn    = b;
            xValid = 1'b1;
            step();
            xValid = 1'b0;
            checkOutput("bit_cnt", bitCnt, i + 1);
            checkOutput("valid_timing", wordValid, (i == FRAME - 1));
        end
        e.word = data;
        e.err  = par ^ (^data);
        expQ.push_back(e);
    endtask

    task automatic checkWord();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = expQ.pop_front();
            checkOutput("word_o", word, e.word);
            checkOutput("word_valid", wordValid, 1);
            checkOutput("done_cnt", bitCnt, FRAME);
`ifdef SIPO_PARITY_EN
            checkOutput("parity_err", parityErr, e.err);
`endif
        end
    endtask

    task automatic transferWord(input bit withStart);
        readyIn = 1'b1;
        startIn = withStart;
        step();
        readyIn = 1'b0;
        startIn = 1'b0;
        checkOutput("xfer_valid", wordValid, 0);
        checkOutput("xfer_busy", busy, withStart);
        checkOutput("xfer_cnt", bitCnt, 0);
    endtask

    initial begin
        vecs.push_back('{4'b1011, 1'b1, 1'b0});
        vecs.push_back('{4'b0110, 1'b0, 1'b1});
        vecs.push_back('{4'b1100, 1'b0, 1'b0});
        vecs.push_back('{4'b0001, 1'b1, 1'b1});
        vecs.push_back('{4'b1111, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 1'b0, 1'b1});
        vecs.push_back('{4'b1011, 1'b0, 1'b0});
        vecs.push_back('{4'b0110, 1'b1, 1'b1});

        step();
        doReset();

        // Serial bits while idle must be ignored.
        xValid = 1'b1;
        xIn    = 1'b1;
        step();
        step();
        xValid = 1'b0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_cnt", bitCnt, 0);
        checkOutput("idle_overrun", overrun, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].data, vecs[k].par, vecs[k].gapped, 1'b1, -1);
            checkWord();
            transferWord(1'b0);
            checkOutput("table_overrun", overrun, 0);
        end

        // Consumer stalls, then a back-to-back word starts on the handshake.
        applyStimulus(4'b1011, 1'b1, 1'b0, 1'b1, -1);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("hold_word", word, 4'b1011);
            checkOutput("hold_valid", wordValid, 1);
        end
        checkWord();
        transferWord(1'b1);
        checkOutput("b2b_overrun", overrun, 0);
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, -1);
        checkWord();
        transferWord(1'b0);

        // Stray start mid-word, then a dropped bit while DONE.
        doReset();
        applyStimulus(4'b1101, 1'b1, 1'b0, 1'b1, 2);
        xIn    = 1'b0;
        xValid = 1'b1;
        step();
        xValid = 1'b0;
        checkOutput("done_drop_overrun", overrun, 1);
        checkWord();
        transferWord(1'b0);
        checkOutput("overrun_sticky", overrun, 1);

        // Reset in the middle of a word, then a fresh frame.
        startIn = 1'b1;
        step();
        startIn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            xIn    = 1'b1;
            xValid = 1'b1;
            step();
        end
        xValid = 1'b0;
        checkOutput("pre_reset_cnt", bitCnt, 3);
        doReset();
        applyStimulus(4'b1100, 1'b0, 1'b0, 1'b1, -1);
        checkWord();
        transferWord(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
